// File: rtl/program_loader_if.sv
// Instruction stream handshake between an upstream image source and the loader.
// The source drives a word with valid/last and the loader answers with ready.
interface program_loader_if #(
  parameter int N = 32
);
  logic         word_valid;
  logic [N-1:0] word_in;
  logic         word_last;
  logic         word_ready;

  modport master (
    output word_valid,
    output word_in,
    output word_last,
    input  word_ready
  );

  modport slave (
    input  word_valid,
    input  word_in,
    input  word_last,
    output word_ready
  );
endinterface

// File: rtl/program_loader.sv
// Boot/programming sequencer for the multi-cycle datapath.
// Streams an instruction image into the unified cache one word per cycle while
// pmode is high. It then holds the CPU in reset with pmode low so PC picks up
// init_PC, and finally releases the CPU to run.
module program_loader #(
  parameter int           N           = 32,
  parameter int           MAX_WORDS   = 1024,
  parameter int           BOOT_CYCLES = 2,
  parameter logic [N-1:0] PARK_ADDR   = {N{1'b1}}
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           abort,
  input  logic [N-1:0]   base_addr,
  input  logic [N-1:0]   entry_pc,
  program_loader_if.slave word_if,
  output logic [N-1:0]   program_data,
  output logic [N-1:0]   addr,
  output logic           pmode,
  output logic [N-1:0]   init_PC,
  output logic           cpu_reset,
  output logic           busy,
  output logic           done,
  output logic           error
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    BOOT,
    RUN
  } state_t;

  localparam int            BW        = $clog2(BOOT_CYCLES + 1);
  localparam logic [N-1:0]  LAST_SLOT = N'(MAX_WORDS - 1);
  localparam logic [BW-1:0] BOOT_LOAD = BW'(BOOT_CYCLES);
  localparam logic [BW-1:0] BOOT_ONE  = BW'(1);

  state_t        state_q, state_d;
  logic [N-1:0]  count_q, count_d;
  logic [N-1:0]  base_q, base_d;
  logic [N-1:0]  program_q, program_d;
  logic [N-1:0]  addr_q, addr_d;
  logic [N-1:0]  init_pc_q, init_pc_d;
  logic          error_q, error_d;
  logic [BW-1:0] boot_cnt_q, boot_cnt_d;

  logic          word_ready_w;
  logic          pmode_w;
  logic          cpu_reset_w;
  logic          busy_w;
  logic          done_w;

  // Register all loader state; reset parks the cache address and clears the image pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      base_q     <= '0;
      program_q  <= '0;
      addr_q     <= PARK_ADDR;
      init_pc_q  <= '0;
      error_q    <= 1'b0;
      boot_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      base_q     <= base_d;
      program_q  <= program_d;
      addr_q     <= addr_d;
      init_pc_q  <= init_pc_d;
      error_q    <= error_d;
      boot_cnt_q <= boot_cnt_d;
    end
  end

  // Next-state logic: addr parks unless a word is accepted this cycle, and abort overrides everything else.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    base_d     = base_q;
    program_d  = program_q;
    addr_d     = PARK_ADDR;
    init_pc_d  = init_pc_q;
    error_d    = error_q;
    boot_cnt_d = boot_cnt_q;

    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d   = LOAD;
            base_d    = base_addr;
            init_pc_d = entry_pc;
            count_d   = '0;
            error_d   = 1'b0;
          end
        end
        LOAD: begin
          if (word_if.word_valid) begin
            program_d = word_if.word_in;
            addr_d    = base_q + count_q;
            count_d   = count_q + 1'b1;
            if (word_if.word_last) begin
              state_d = FLUSH;
            end else if (count_q == LAST_SLOT) begin
              error_d = 1'b1;
              state_d = IDLE;
            end
          end
        end
        FLUSH: begin
          state_d    = BOOT;
          boot_cnt_d = BOOT_LOAD;
        end
        BOOT: begin
          if (boot_cnt_q <= BOOT_ONE) begin
            state_d = RUN;
          end else begin
            boot_cnt_d = boot_cnt_q - 1'b1;
          end
        end
        RUN: begin
          state_d = RUN;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Datapath control pins decode straight from state so an async reset takes effect immediately.
  always_comb begin
    pmode_w      = 1'b1;
    cpu_reset_w  = 1'b1;
    word_ready_w = 1'b0;
    busy_w       = 1'b0;
    done_w       = 1'b0;
    case (state_q)
      IDLE: begin
        pmode_w = 1'b1;
      end
      LOAD: begin
        word_ready_w = 1'b1;
        busy_w       = 1'b1;
      end
      FLUSH: begin
        busy_w = 1'b1;
      end
      BOOT: begin
        pmode_w = 1'b0;
        busy_w  = 1'b1;
      end
      RUN: begin
        pmode_w     = 1'b0;
        cpu_reset_w = 1'b0;
        done_w      = 1'b1;
      end
      default: begin
        pmode_w = 1'b1;
      end
    endcase
  end

  assign word_if.word_ready = word_ready_w;
  assign program_data       = program_q;
  assign addr               = addr_q;
  assign pmode              = pmode_w;
  assign init_PC            = init_pc_q;
  assign cpu_reset          = cpu_reset_w;
  assign busy               = busy_w;
  assign done               = done_w;
  assign error              = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a write scoreboard.
// Every word the loader should accept is queued as {addr, data}; each cycle a
// non-parked addr must match the head of the queue, and a parked addr is a no-op.
module tb_program_loader;

  localparam int          N    = 32;
  localparam logic [31:0] PARK = 32'hFFFF_FFFF;

  logic          clk;
  logic          reset;
  logic          start;
  logic          abort;
  logic [N-1:0]  base_addr;
  logic [N-1:0]  entry_pc;
  logic [N-1:0]  program_data;
  logic [N-1:0]  addr;
  logic          pmode;
  logic [N-1:0]  init_PC;
  logic          cpu_reset;
  logic          busy;
  logic          done;
  logic          error;

  int            compared;
  int            mismatched;
  logic [63:0]   exp_q[$];

  program_loader_if #(.N(N)) word_if ();

  program_loader #(
    .N(N),
    .MAX_WORDS(4),
    .BOOT_CYCLES(2),
    .PARK_ADDR(PARK)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .abort(abort),
    .base_addr(base_addr),
    .entry_pc(entry_pc),
    .word_if(word_if),
    .program_data(program_data),
    .addr(addr),
    .pmode(pmode),
    .init_PC(init_PC),
    .cpu_reset(cpu_reset),
    .busy(busy),
    .done(done),
    .error(error)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample 1ns after the edge and score any presented cache write.
  task automatic tick();
    logic [63:0] e;
    @(posedge clk);
    #1;
    if (addr !== PARK) begin
      if (exp_q.size() == 0) begin
        check("spurious_write_addr", addr, PARK);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", addr, e[63:32]);
        check("write_data", program_data, e[31:0]);
        check("write_pmode", pmode, 1);
      end
    end
  endtask

  task automatic send_word(input logic [31:0] wa, input logic [31:0] wd, input logic last, input logic expect_write);
    word_if.word_valid = 1'b1;
    word_if.word_in    = wd;
    word_if.word_last  = last;
    if (expect_write) exp_q.push_back({wa, wd});
    tick();
    word_if.word_valid = 1'b0;
    word_if.word_last  = 1'b0;
  endtask

  task automatic do_start(input logic [31:0] b, input logic [31:0] e);
    start     = 1'b1;
    base_addr = b;
    entry_pc  = e;
    tick();
    start     = 1'b0;
    base_addr = 32'h0;
    entry_pc  = 32'h0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    base_addr  = '0;
    entry_pc   = '0;
    word_if.word_valid = 1'b0;
    word_if.word_in    = '0;
    word_if.word_last  = 1'b0;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tick();

    // Idle after reset
    check("rst_pmode", pmode, 1);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_word_ready", word_if.word_ready, 0);
    check("rst_addr", addr, PARK);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_busy", busy, 0);

    // Back-to-back image of three words
    do_start(32'h10, 32'h40);
    check("load_busy", busy, 1);
    check("load_ready", word_if.word_ready, 1);
    check("load_init_pc", init_PC, 32'h40);
    for (int i = 0; i < 3; i++) begin
      send_word(32'h10 + 32'(i), 32'hA000_0000 + 32'(i), (i == 2), 1'b1);
    end
    check("flush_pmode", pmode, 1);
    check("flush_busy", busy, 1);
    check("flush_ready", word_if.word_ready, 0);
    for (int b = 0; b < 2; b++) begin
      tick();
      check("boot_pmode", pmode, 0);
      check("boot_cpu_reset", cpu_reset, 1);
      check("boot_init_pc", init_PC, 32'h40);
      check("boot_addr", addr, PARK);
      check("boot_done", done, 0);
    end
    tick();
    check("run_done", done, 1);
    check("run_cpu_reset", cpu_reset, 0);
    check("run_pmode", pmode, 0);
    check("run_busy", busy, 0);
    start     = 1'b1;
    base_addr = 32'h77;
    entry_pc  = 32'h99;
    tick();
    start = 1'b0;
    check("run_ignores_start", done, 1);
    check("run_init_pc_stable", init_PC, 32'h40);
    check("img1_drained", exp_q.size(), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_run_done", done, 0);
    check("abort_run_pmode", pmode, 1);

    // Same image with a park cycle between words
    do_start(32'h10, 32'h40);
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) begin
        send_word(32'h10 + 32'(i / 2), 32'hB000_0000 + 32'(i / 2), (i == 4), 1'b1);
      end else begin
        tick();
        check("gap_park", addr, PARK);
      end
    end
    repeat (3) tick();
    check("gap_run_done", done, 1);
    check("gap_drained", exp_q.size(), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Four words without last overflow a MAX_WORDS=4 loader
    do_start(32'h100, 32'h8);
    for (int i = 0; i < 4; i++) begin
      send_word(32'h100 + 32'(i), 32'hE000_0000 + 32'(i), 1'b0, 1'b1);
    end
    check("ovf_error", error, 1);
    check("ovf_busy", busy, 0);
    check("ovf_ready", word_if.word_ready, 0);
    repeat (3) tick();
    check("ovf_no_boot_pmode", pmode, 1);
    check("ovf_no_run", done, 0);
    check("ovf_sticky", error, 1);
    check("ovf_drained", exp_q.size(), 0);
    do_start(32'h20, 32'h24);
    check("start_clears_error", error, 0);
    check("restart_busy", busy, 1);

    // Abort while the second word is offered
    send_word(32'h20, 32'hC0, 1'b0, 1'b1);
    abort = 1'b1;
    send_word(32'h21, 32'hC1, 1'b0, 1'b0);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_pmode", pmode, 1);
    check("abort_cpu_reset", cpu_reset, 1);
    check("abort_addr", addr, PARK);
    check("abort_program_holds", program_data, 32'hC0);
    tick();
    check("abort_stays_idle", busy, 0);
    check("abort_drained", exp_q.size(), 0);

    // Async reset in the middle of a RUN cycle
    do_start(32'h30, 32'h50);
    send_word(32'h30, 32'hD0, 1'b1, 1'b1);
    repeat (3) tick();
    check("pre_reset_done", done, 1);
    #3 reset = 1'b1;
    #1;
    check("async_pmode", pmode, 1);
    check("async_cpu_reset", cpu_reset, 1);
    check("async_done", done, 0);
    check("async_addr", addr, PARK);
    check("async_init_pc", init_PC, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    check("post_reset_busy", busy, 0);
    check("post_reset_pmode", pmode, 1);
    check("final_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
